// File: rtl/eth_pkg.sv
// Shared Ethernet constants, transmitter state encoding and the reflected CRC-32 byte step.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam int unsigned BYTE_CNT_W      = 11;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  // One byte through the reflected CRC-32, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register; init and en may coincide, in which case the byte is folded into
// a freshly initialised value.
module eth_crc32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);
  import eth_pkg::*;

  logic [31:0] r_crc;
  logic [31:0] w_base;
  logic [31:0] w_next;

  always_comb begin
    w_base = i_init ? 32'hFFFF_FFFF : r_crc;
    w_next = i_en ? crc32_byte(w_base, i_data) : w_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= 32'hFFFF_FFFF;
    end else begin
      r_crc <= w_next;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/eth_rmii_tx.sv
// RMII 100Mb/s transmitter: preamble/SFD, payload, optional zero pad and FCS, then the IFG.
// Two bits per clk50 cycle, LSB first; the next byte is taken in the last dibit of a byte.
module eth_rmii_tx #(
  parameter int unsigned IFG_BYTES = 12,
  parameter int unsigned MIN_LEN   = 60,
  parameter int unsigned PAD_EN    = 1,
  parameter int unsigned FCS_EN    = 1
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_eop,
  output logic       o_ready,
  output logic       o_busy,
  output logic       o_underrun,
  output logic       o_txen,
  output logic       o_tx0,
  output logic       o_tx1
);
  import eth_pkg::*;

  localparam int unsigned IFG_CYC = IFG_BYTES * 4;
  localparam int unsigned IFG_W   = (IFG_CYC > 2) ? $clog2(IFG_CYC) : 1;

  tx_state_t              r_state, w_state_d;
  logic [1:0]             r_dibit, w_dibit_d;
  logic [BYTE_CNT_W-1:0]  r_byte_cnt, w_byte_cnt_d;
  logic [7:0]             r_shift, w_shift_d;
  logic                   r_last, w_last_d;
  logic [IFG_W-1:0]       r_ifg_cnt, w_ifg_cnt_d;

  logic                   w_crc_init, w_crc_en;
  logic [7:0]             w_crc_data;
  logic [31:0]            w_crc, w_crc_inv;
  logic [1:0]             w_fcs_idx;
  logic [7:0]             w_fcs_byte;
  logic                   w_byte_end, w_ready, w_underrun, w_txen, w_pad_more, w_tail;
  logic [BYTE_CNT_W-1:0]  w_cnt_sat;

  assign w_byte_end = (r_dibit == 2'd3);
  assign w_ready    = w_byte_end && ((r_state == SFD) || ((r_state == DATA) && !r_last));
  assign w_underrun = w_ready && !i_valid;
  assign w_cnt_sat  = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + 1'b1;
  assign w_pad_more = (PAD_EN != 0) && (r_byte_cnt < BYTE_CNT_W'(MIN_LEN));
  assign w_crc_inv  = ~w_crc;
  assign w_fcs_idx  = r_byte_cnt[1:0] + 2'd1;
  assign w_fcs_byte = 8'(w_crc_inv >> {w_fcs_idx, 3'b000});
  assign w_txen     = (r_state == PRE) || (r_state == SFD) || (r_state == DATA) ||
                      (r_state == PAD) || (r_state == FCS);

  always_comb begin
    w_state_d    = r_state;
    w_dibit_d    = r_dibit + 2'd1;
    w_byte_cnt_d = r_byte_cnt;
    w_shift_d    = {2'b00, r_shift[7:2]};
    w_last_d     = r_last;
    w_ifg_cnt_d  = r_ifg_cnt;
    w_crc_init   = 1'b0;
    w_crc_en     = 1'b0;
    w_crc_data   = i_data;
    w_tail       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_dibit_d = 2'd0;
        if (i_valid) begin
          w_state_d    = PRE;
          w_shift_d    = ETH_PREAMBLE;
          w_byte_cnt_d = '0;
        end
      end
      PRE: begin
        if (w_byte_end) begin
          if (r_byte_cnt == BYTE_CNT_W'(6)) begin
            w_state_d = SFD;
            w_shift_d = ETH_SFD;
          end else begin
            w_byte_cnt_d = r_byte_cnt + 1'b1;
            w_shift_d    = ETH_PREAMBLE;
          end
        end
      end
      SFD: begin
        w_crc_init = 1'b1;
        if (w_byte_end) begin
          if (i_valid) begin
            w_state_d    = DATA;
            w_shift_d    = i_data;
            w_last_d     = i_eop;
            w_byte_cnt_d = BYTE_CNT_W'(1);
            w_crc_en     = 1'b1;
          end else begin
            w_state_d   = IFG;
            w_ifg_cnt_d = IFG_W'(IFG_CYC - 1);
          end
        end
      end
      DATA: begin
        if (w_byte_end) begin
          if (r_last) begin
            w_tail = 1'b1;
          end else if (i_valid) begin
            w_shift_d    = i_data;
            w_last_d     = i_eop;
            w_byte_cnt_d = w_cnt_sat;
            w_crc_en     = 1'b1;
          end else begin
            w_state_d   = IFG;
            w_ifg_cnt_d = IFG_W'(IFG_CYC - 1);
          end
        end
      end
      PAD: begin
        if (w_byte_end) begin
          w_tail = 1'b1;
        end
      end
      FCS: begin
        if (w_byte_end) begin
          if (r_byte_cnt[1:0] == 2'd3) begin
            w_state_d   = IFG;
            w_ifg_cnt_d = IFG_W'(IFG_CYC - 1);
          end else begin
            w_byte_cnt_d = r_byte_cnt + 1'b1;
            w_shift_d    = w_fcs_byte;
          end
        end
      end
      IFG: begin
        w_dibit_d = 2'd0;
        if (r_ifg_cnt == '0) begin
          // A waiting frame starts straight from the last gap cycle so the gap stays exact.
          if (i_valid) begin
            w_state_d    = PRE;
            w_shift_d    = ETH_PREAMBLE;
            w_byte_cnt_d = '0;
          end else begin
            w_state_d = IDLE;
          end
        end else begin
          w_ifg_cnt_d = r_ifg_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase

    // End of the last payload or pad byte: more pad, then FCS, then gap.
    if (w_tail) begin
      if (w_pad_more) begin
        w_state_d    = PAD;
        w_shift_d    = 8'h00;
        w_byte_cnt_d = w_cnt_sat;
        w_crc_en     = 1'b1;
        w_crc_data   = 8'h00;
      end else if (FCS_EN != 0) begin
        w_state_d    = FCS;
        w_shift_d    = w_crc_inv[7:0];
        w_byte_cnt_d = '0;
      end else begin
        w_state_d   = IFG;
        w_ifg_cnt_d = IFG_W'(IFG_CYC - 1);
      end
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_dibit    <= 2'd0;
      r_byte_cnt <= '0;
      r_shift    <= 8'h00;
      r_last     <= 1'b0;
      r_ifg_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_dibit    <= w_dibit_d;
      r_byte_cnt <= w_byte_cnt_d;
      r_shift    <= w_shift_d;
      r_last     <= w_last_d;
      r_ifg_cnt  <= w_ifg_cnt_d;
    end
  end

  eth_crc32 u_crc (
    .clk    (clk50),
    .rst_n  (rst_n),
    .i_init (w_crc_init),
    .i_en   (w_crc_en),
    .i_data (w_crc_data),
    .o_crc  (w_crc)
  );

  assign o_ready    = w_ready;
  assign o_busy     = (r_state != IDLE);
  assign o_underrun = w_underrun;
  assign o_txen     = w_txen;
  assign o_tx0      = w_txen & r_shift[0];
  assign o_tx1      = w_txen & r_shift[1];

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Scoreboard bench for eth_rmii_tx: stimulus pushes expected wire frames, a monitor decodes
// the RMII line and compares each frame when txen falls.
module tb_eth_rmii_tx;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       eop   = 1'b0;
  logic       sel   = 1'b0;  // 1: route stimulus and monitor to the no-pad instance

  logic a_valid, a_ready, a_busy, a_underrun, a_txen, a_tx0, a_tx1;
  logic b_valid, b_ready, b_busy, b_underrun, b_txen, b_tx0, b_tx1;
  logic m_ready, m_busy, m_underrun, m_txen, m_tx0, m_tx1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk50 = ~clk50;

  assign a_valid = valid & ~sel;
  assign b_valid = valid & sel;

  eth_rmii_tx u_dut (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .i_data     (data),
    .i_valid    (a_valid),
    .i_eop      (eop),
    .o_ready    (a_ready),
    .o_busy     (a_busy),
    .o_underrun (a_underrun),
    .o_txen     (a_txen),
    .o_tx0      (a_tx0),
    .o_tx1      (a_tx1)
  );

  eth_rmii_tx #(.PAD_EN(0), .FCS_EN(1)) u_dut_np (
    .clk50      (clk50),
    .rst_n      (rst_n),
    .i_data     (data),
    .i_valid    (b_valid),
    .i_eop      (eop),
    .o_ready    (b_ready),
    .o_busy     (b_busy),
    .o_underrun (b_underrun),
    .o_txen     (b_txen),
    .o_tx0      (b_tx0),
    .o_tx1      (b_tx1)
  );

  assign m_ready    = sel ? b_ready    : a_ready;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_underrun = sel ? b_underrun : a_underrun;
  assign m_txen     = sel ? b_txen     : a_txen;
  assign m_tx0      = sel ? b_tx0      : a_tx0;
  assign m_tx1      = sel ? b_tx1      : a_tx1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else c = c >> 1;
    end
    return c;
  endfunction

  // Scoreboard queues
  logic [7:0] exp_bytes[$];
  int         exp_len[$];
  bit         exp_resid[$];
  logic [7:0] pay[$];

  // Monitor state
  logic [7:0] mon_frame[$];
  logic [7:0] mon_cur = 8'h00;
  int         mon_pos = 0;
  int         mon_gap = 0;
  int         last_gap = 0;
  int         und_pulses = 0;
  bit         mon_prev_txen = 1'b0;
  bit         mon_ignore = 1'b0;

  task automatic frame_end();
    int         elen, nb, errs;
    logic [7:0] eb, ab;
    logic [31:0] c;
    string      where;
    if (mon_ignore) begin
      mon_ignore = 1'b0;
      return;
    end
    if (exp_len.size() == 0) begin
      check("unexpected_frame_len", mon_pos, 0);
      return;
    end
    elen = exp_len.pop_front();
    check("txen_len", mon_pos, elen);
    nb    = elen / 4;
    errs  = 0;
    where = "frame_bytes";
    for (int i = 0; i < nb; i++) begin
      eb = (exp_bytes.size() > 0) ? exp_bytes.pop_front() : 8'hxx;
      ab = (i < mon_frame.size()) ? mon_frame[i] : 8'hxx;
      if (ab !== eb) begin
        if (errs == 0) where = $sformatf("frame_bytes[%0d] got %02h want %02h", i, ab, eb);
        errs++;
      end
    end
    check(where, errs, 0);
    if (exp_resid.pop_front()) begin
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < mon_frame.size(); i++) c = crc_ref(c, mon_frame[i]);
      check("rx_crc_residue", c, eth_pkg::CRC32_RESIDUE);
    end
    check("idle_line", {30'd0, m_tx1, m_tx0}, 0);
  endtask

  initial begin
    int pos_now;
    forever begin
      @(negedge clk50);
      if (m_underrun) und_pulses++;
      if (m_ready) begin
        pos_now = (m_txen && mon_prev_txen) ? mon_pos : 0;
        check("ready_phase", {30'd0, m_txen, 1'(pos_now % 4 == 3)}, 32'd3);
      end
      if (m_txen) begin
        if (!mon_prev_txen) begin
          last_gap = mon_gap;
          mon_pos  = 0;
          mon_frame.delete();
        end
        mon_cur = {m_tx1, m_tx0, mon_cur[7:2]};
        mon_pos++;
        if (mon_pos % 4 == 0) mon_frame.push_back(mon_cur);
      end else begin
        if (mon_prev_txen) begin
          frame_end();
          mon_gap = 1;
        end else begin
          mon_gap++;
        end
      end
      mon_prev_txen = m_txen;
    end
  end

  task automatic push_preamble();
    repeat (7) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
  endtask

  task automatic expect_frame(input int n);
    logic [31:0] c;
    int          body;
    push_preamble();
    c    = 32'hFFFF_FFFF;
    body = 0;
    for (int i = 0; i < n; i++) begin
      exp_bytes.push_back(pay[i]);
      c = crc_ref(c, pay[i]);
      body++;
    end
    while (body < 60) begin
      exp_bytes.push_back(8'h00);
      c = crc_ref(c, 8'h00);
      body++;
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_bytes.push_back(c[8*i +: 8]);
    exp_len.push_back(4 * (8 + body + 4));
    exp_resid.push_back(1'b1);
  endtask

  task automatic drive_frame(input int n, input int abort_at, input bit rand_valid,
                             input bit hold_after);
    int idx, guard;
    idx   = 0;
    guard = 0;
    while (idx < n && guard < 4000) begin
      @(posedge clk50);
      #1;
      guard++;
      if (abort_at >= 0 && idx == abort_at && m_ready) begin
        valid = 1'b0;
        return;
      end
      data  = pay[idx];
      eop   = (idx == n - 1);
      valid = (rand_valid && !m_ready) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_ready && valid) idx++;
    end
    if (idx < n) check("drive_timeout", idx, n);
    if (!hold_after) begin
      @(posedge clk50);
      #1;
      valid = 1'b0;
      eop   = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk50);
      #1;
      n++;
    end while (m_busy && n < 3000);
    check("idle_reached", m_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int n, und0;
    repeat (3) @(posedge clk50);
    #1;
    check("reset_outputs", {26'd0, a_txen, a_tx0, a_tx1, a_ready, a_busy, a_underrun}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk50);
    #1;

    // 1: "123456789", no pad, hand-known FCS
    sel = 1'b1;
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    push_preamble();
    for (int i = 0; i < 9; i++) exp_bytes.push_back(8'h31 + 8'(i));
    exp_bytes.push_back(8'h26);
    exp_bytes.push_back(8'h39);
    exp_bytes.push_back(8'hF4);
    exp_bytes.push_back(8'hCB);
    exp_len.push_back(84);
    exp_resid.push_back(1'b1);
    drive_frame(9, -1, 1'b0, 1'b0);
    wait_idle();
    sel = 1'b0;

    // 2: 14-byte payload, padded to 60
    pay.delete();
    for (int i = 0; i < 14; i++) pay.push_back(8'hA0 + 8'(i));
    expect_frame(14);
    drive_frame(14, -1, 1'b0, 1'b0);
    wait_idle();

    // 3: underrun at the ready cycle of the fifth payload byte
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h60 + 8'(i));
    push_preamble();
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'h60 + 8'(i));
    exp_len.push_back(48);
    exp_resid.push_back(1'b0);
    und0 = und_pulses;
    drive_frame(9, 4, 1'b0, 1'b1);
    @(posedge clk50);
    #1;
    check("txen_after_underrun", m_txen, 0);
    n = 0;
    while (m_busy && n < 200) begin
      n++;
      @(posedge clk50);
      #1;
    end
    check("busy_after_underrun", n, 48);
    check("underrun_pulses", und_pulses - und0, 1);

    // 4: back-to-back, valid held high across both frames
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'hC0 + 8'(i));
    expect_frame(5);
    drive_frame(5, -1, 1'b0, 1'b1);
    pay.delete();
    for (int i = 0; i < 61; i++) pay.push_back(8'(i * 3 + 1));
    expect_frame(61);
    drive_frame(61, -1, 1'b0, 1'b0);
    wait_idle();
    check("ifg_gap", last_gap, 48);

    // 5: reset in the middle of padding, then a clean frame
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(8'hE0 + 8'(i));
    mon_ignore = 1'b1;
    drive_frame(3, -1, 1'b0, 1'b0);
    repeat (20) @(posedge clk50);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_txen", a_txen, 0);
    check("rst_ready", a_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_underrun", a_underrun, 0);
    repeat (2) @(posedge clk50);
    #1;
    rst_n = 1'b1;
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'h11 * 8'(i + 1));
    expect_frame(10);
    drive_frame(10, -1, 1'b0, 1'b0);
    wait_idle();

    // 6: random valid, always high when ready
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'($urandom_range(0, 255)));
    expect_frame(20);
    drive_frame(20, -1, 1'b1, 1'b0);
    wait_idle();

    repeat (5) @(posedge clk50);
    check("pending_frames", exp_len.size(), 0);
    check("total_underruns", und_pulses, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
